intpipe_issue: RTL and testbench

INTPIPE_ISSUE -- requirements
Module: intpipe_issue

---
 rtl/intpipe_pkg.sv | 17 +
 rtl/issue_fifo.sv | 50 +++++
 rtl/intpipe_issue.sv | 86 ++++++++
 tb/tb_intpipe_issue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/intpipe_pkg.sv
// Shared widths, NOP opcode and the queued-instruction layout for the integer pipe
// and its issue stage.
package intpipe_pkg;
  localparam int OP_W  = 5;
  localparam int SEL_W = 4;
  localparam int NREG  = 1 << SEL_W;
  localparam logic [OP_W-1:0] OP_NOP = 5'd0;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [SEL_W-1:0] a;
    logic [SEL_W-1:0] b;
    logic [SEL_W-1:0] c;
  } instr_t;

  localparam int INSTR_W = $bits(instr_t);
endpackage

// File: rtl/issue_fifo.sv
// Instruction queue: DEPTH-entry circular FIFO with a combinational head view.
// Ready depends only on the registered count, so a pop never frees a slot for a
// push in the same cycle.
module issue_fifo import intpipe_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = INSTR_W,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_ready
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign o_ready = (r_cnt < CW'(DEPTH));
  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end
endmodule

// File: rtl/intpipe_issue.sv
// In-order issue stage: queues instructions, blocks the head on RAW/WAW hazards
// via a per-register pending scoreboard, and drives registered issue/pause/bubble.
module intpipe_issue import intpipe_pkg::*; #(
  parameter int              DEPTH  = 4,
  parameter logic [OP_W-1:0] OP_NOP = intpipe_pkg::OP_NOP,
  localparam int             CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [SEL_W-1:0] in_a,
  input  logic [SEL_W-1:0] in_b,
  input  logic [SEL_W-1:0] in_c,
  input  logic             hold,
  input  logic             wb_write,
  input  logic [SEL_W-1:0] wb_sel,
  output logic [OP_W-1:0]  opCode,
  output logic [SEL_W-1:0] a,
  output logic [SEL_W-1:0] b,
  output logic [SEL_W-1:0] c,
  output logic             pause,
  output logic             empty,
  output logic             idle
);
  instr_t          w_din, w_head;
  logic [CW-1:0]   w_count;
  logic            w_ready, w_blocked, w_issue;
  logic [NREG-1:0] r_pend, w_pend_nxt;
  instr_t          r_out;
  logic            r_empty, r_pause;

  assign w_din = '{op: in_op, a: in_a, b: in_b, c: in_c};

  issue_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_pop   (w_issue),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_count (w_count),
    .o_ready (w_ready)
  );

  assign w_blocked = r_pend[w_head.a] | r_pend[w_head.b] | r_pend[w_head.c];
  assign w_issue   = (w_count != '0) && !hold && !w_blocked;

  // Clear first so a same-cycle issue to the same register leaves it pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (wb_write) w_pend_nxt[wb_sel] = 1'b0;
    if (w_issue && (w_head.op != OP_NOP)) w_pend_nxt[w_head.c] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= '0;
      r_out   <= '{op: OP_NOP, a: '0, b: '0, c: '0};
      r_empty <= 1'b1;
      r_pause <= 1'b0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_pause <= hold;
      if (!hold) begin
        if (w_issue) begin
          r_out   <= w_head;
          r_empty <= 1'b0;
        end else begin
          r_out   <= '{op: OP_NOP, a: '0, b: '0, c: '0};
          r_empty <= 1'b1;
        end
      end
    end
  end

  assign in_ready = w_ready;
  assign opCode   = r_out.op;
  assign a        = r_out.a;
  assign b        = r_out.b;
  assign c        = r_out.c;
  assign pause    = r_pause;
  assign empty    = r_empty;
  assign idle     = (w_count == '0) && (r_pend == '0);
endmodule

// File: tb/tb_intpipe_issue.sv
// Scoreboard bench for intpipe_issue: accepted pushes queue their expected issue,
// and every fresh issue on the outputs pops and compares in order.
module tb_intpipe_issue;
  import intpipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, hold, wb_write;
  logic [4:0] in_op, opCode;
  logic [3:0] in_a, in_b, in_c, wb_sel, a, b, c;
  logic       pause, empty, idle;

  int n_tot = 0;
  int n_bad = 0;
  logic [16:0] sb[$];

  intpipe_issue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_c(in_c), .hold(hold),
    .wb_write(wb_write), .wb_sel(wb_sel), .opCode(opCode), .a(a), .b(b), .c(c),
    .pause(pause), .empty(empty), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A non-empty, non-paused output is a fresh issue every cycle.
  always @(negedge clk) begin : mon
    logic [16:0] e;
    if (!rst && !empty && !pause) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("issue", {opCode, a, b, c}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    logic acc;
    in_valid = 1'b1; in_op = op; in_a = ra; in_b = rb; in_c = rc;
    acc = in_ready;
    @(posedge clk);
    if (acc) sb.push_back({op, ra, rb, rc});
    #1 in_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] s);
    wb_write = 1'b1; wb_sel = s;
    tick();
    wb_write = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk); k++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_c = '0;
    hold = 1'b0; wb_write = 1'b0; wb_sel = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", {opCode, a, b, c}, 0);
    chk("rst_empty", empty, 1);
    chk("rst_pause", pause, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
    rst = 1'b0;
    @(negedge clk);

    // single add: issued one edge after the push edge
    push(5'd1, 4'd0, 4'd1, 4'd2);
    @(negedge clk);
    chk("s1_pre_empty", empty, 1);
    @(negedge clk);
    chk("s1_op", opCode, 1);
    chk("s1_c", c, 2);
    chk("s1_empty", empty, 0);
    chk("s1_pend2", dut.r_pend[2], 1);
    chk("s1_idle", idle, 0);
    wb(4'd2);
    @(negedge clk);
    chk("s1_idle_after_wb", idle, 1);

    // RAW stall until writeback of r2
    push(5'd1, 4'd0, 4'd0, 4'd2);
    push(5'd3, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      chk("s2_stall", empty, 1);
      chk("s2_cnt", dut.w_count, 1);
    end
    wb(4'd2);
    @(negedge clk);
    chk("s2_wb_edge", empty, 1);
    @(negedge clk);
    chk("s2_issue_op", opCode, 3);
    chk("s2_issue_empty", empty, 0);
    wb(4'd4);

    // writeback and issue on the same register in one cycle: set wins
    push(5'd2, 4'd0, 4'd0, 4'd6);
    wb_write = 1'b1; wb_sel = 4'd6;
    tick();
    wb_write = 1'b0;
    @(negedge clk);
    chk("set_wins", dut.r_pend[6], 1);
    wb(4'd6);
    @(negedge clk);
    chk("pend_clear", dut.r_pend, 0);

    // fill to DEPTH under hold; fifth push refused
    hold = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) push(5'd4, 4'd0, 4'd0, 4'(8 + i));
    @(negedge clk);
    chk("s3_ready", in_ready, 0);
    chk("s3_cnt", dut.w_count, 4);
    chk("s3_pause", pause, 1);
    hold = 1'b0;
    drain();
    for (int i = 8; i < 12; i++) wb(4'(i));

    // hold mid-stream: frozen outputs, no pops, in-order resume
    push(5'd5, 4'd0, 4'd0, 4'd1);
    push(5'd5, 4'd0, 4'd0, 4'd3);
    hold = 1'b1;
    push(5'd5, 4'd0, 4'd0, 4'd9);
    push(5'd5, 4'd0, 4'd0, 4'd10);
    repeat (8) begin
      @(negedge clk);
      chk("s4_pause", pause, 1);
      chk("s4_frozen", {opCode, a, b, c}, {5'd5, 4'd0, 4'd0, 4'd1});
      chk("s4_cnt", dut.w_count, 3);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("s4_pause_rel", pause, 0);
    drain();
    wb(4'd1); wb(4'd3); wb(4'd9); wb(4'd10);

    // NOP leaves its destination clear; reader follows without stall
    push(5'd0, 4'd0, 4'd0, 4'd5);
    push(5'd2, 4'd5, 4'd5, 4'd7);
    @(negedge clk);
    chk("s5_nop_op", opCode, 0);
    chk("s5_nop_empty", empty, 0);
    chk("s5_pend5", dut.r_pend[5], 0);
    @(negedge clk);
    chk("s5_no_stall", opCode, 2);
    chk("s5_no_stall_empty", empty, 0);
    wb(4'd7);

    // reset with queued and pending work
    push(5'd1, 4'd0, 4'd0, 4'd1);
    push(5'd1, 4'd0, 4'd0, 4'd3);
    tick();
    hold = 1'b1;
    push(5'd6, 4'd0, 4'd0, 4'd12);
    push(5'd6, 4'd0, 4'd0, 4'd13);
    push(5'd6, 4'd0, 4'd0, 4'd14);
    @(negedge clk);
    chk("s6_busy", idle, 0);
    chk("s6_cnt", dut.w_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("s6_idle", idle, 1);
    chk("s6_empty", empty, 1);
    chk("s6_ready", in_ready, 1);
    chk("s6_pause", pause, 0);
    chk("s6_op", opCode, 0);
    chk("s6_pend", dut.r_pend, 0);
    sb.delete();
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wb(4'd1);
    @(negedge clk);
    chk("s6_wb_idle", idle, 1);
    chk("s6_wb_pend", dut.r_pend, 0);
    repeat (3) begin
      @(negedge clk);
      chk("s6_quiet", empty, 1);
    end

    chk("sb_final", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
